// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Source end of the VGA pixel stream. Generates the raster counters, sync and
// blanking flags that every downstream draw stage consumes, plus a one-cycle
// line tick (start of horizontal blanking) and frame tick (start of vertical
// blanking) used to pace game logic.
//
// Ports:
//   clk        in   pixel-domain clock
//   rst        in   synchronous reset, active-low
//   clk_en     in   pixel advance enable (tie high when clk is the pixel clock)
//   vcount     out  [10:0] current line
//   vsync      out  vertical sync, asserted level VSYNC_POL
//   vblnk      out  vertical blanking (vcount >= V_ACTIVE)
//   hcount     out  [10:0] current pixel within the line
//   hsync      out  horizontal sync, asserted level HSYNC_POL
//   hblnk      out  horizontal blanking (hcount >= H_ACTIVE)
//   rgb        out  [11:0] base colour, black unless the test pattern is built
//   frame_tick out  one-cycle pulse when the raster enters (0, V_ACTIVE)
//   line_tick  out  one-cycle pulse when the raster enters hcount == H_ACTIVE
//
// Build option:
//   VGA_TIMING_TEST_PATTERN_EN  when defined, rgb carries 8 vertical colour
//                               bars during active video.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_ACTIVE  = 1024,
   parameter int H_FP      = 24,
   parameter int H_SYNC    = 136,
   parameter int H_BP      = 160,
   parameter int V_ACTIVE  = 768,
   parameter int V_FP      = 3,
   parameter int V_SYNC    = 6,
   parameter int V_BP      = 29,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   output logic [10:0] vcount,
   output logic        vsync,
   output logic        vblnk,
   output logic [10:0] hcount,
   output logic        hsync,
   output logic        hblnk,
   output logic [11:0] rgb,
   output logic        frame_tick,
   output logic        line_tick
);

   localparam int H_TOTAL_I = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL_I = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Counter limits fit in 11 bits; sync window bounds get a 12th bit so a
   // window ending exactly at 2048 still compares correctly.
   localparam logic [10:0] H_MAX    = 11'(H_TOTAL_I - 1);
   localparam logic [10:0] V_MAX    = 11'(V_TOTAL_I - 1);
   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
   localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

   // Refuse to build a mode whose totals overflow the 11-bit counters.
   if (H_TOTAL_I > 2048) begin : g_h_total_check
      $error("vga_timing_gen: H_TOTAL %0d exceeds 2048", H_TOTAL_I);
   end
   if (V_TOTAL_I > 2048) begin : g_v_total_check
      $error("vga_timing_gen: V_TOTAL %0d exceeds 2048", V_TOTAL_I);
   end

   logic [10:0] h_next;
   logic [10:0] v_next;
   logic        hs_on_next;
   logic        vs_on_next;

   // Next raster position. All flags below are decoded from these values and
   // registered together with the counters, so every output describes the
   // pixel shown in the same cycle.
   always_comb begin
      h_next = hcount + 11'd1;
      v_next = vcount;
      if (hcount == H_MAX) begin
         h_next = 11'd0;
         if (vcount == V_MAX) begin
            v_next = 11'd0;
         end else begin
            v_next = vcount + 11'd1;
         end
      end
   end

   // Sync windows for the next position.
   always_comb begin
      hs_on_next = ({1'b0, h_next} >= HS_START) && ({1'b0, h_next} < HS_END);
      vs_on_next = ({1'b0, v_next} >= VS_START) && ({1'b0, v_next} < VS_END);
   end

   // Raster registers. Reset drops straight back to (0,0) with sync released,
   // so a reset in the middle of a sync pulse never leaves it half-held.
   // On disabled cycles everything holds except the ticks, which clear so a
   // tick lasts exactly one clock after the enabled edge that produced it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hcount     <= 11'd0;
         vcount     <= 11'd0;
         hblnk      <= 1'b0;
         vblnk      <= 1'b0;
         hsync      <= ~HSYNC_POL;
         vsync      <= ~VSYNC_POL;
         line_tick  <= 1'b0;
         frame_tick <= 1'b0;
      end else if (clk_en) begin
         hcount     <= h_next;
         vcount     <= v_next;
         hblnk      <= (h_next >= H_ACT);
         vblnk      <= (v_next >= V_ACT);
         hsync      <= hs_on_next ? HSYNC_POL : ~HSYNC_POL;
         vsync      <= vs_on_next ? VSYNC_POL : ~VSYNC_POL;
         line_tick  <= (h_next == H_ACT);
         frame_tick <= (h_next == 11'd0) && (v_next == V_ACT);
      end else begin
         line_tick  <= 1'b0;
         frame_tick <= 1'b0;
      end
   end

`ifdef VGA_TIMING_TEST_PATTERN_EN
   localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

   logic [10:0] bar_idx;
   logic [11:0] bar_rgb;

   // Colour bar for the next pixel; black whenever that pixel is blanked.
   always_comb begin
      bar_idx = h_next / BAR_W;
      bar_rgb = 12'h000;
      if ((h_next < H_ACT) && (v_next < V_ACT)) begin
         case (bar_idx)
            11'd0:   bar_rgb = 12'hFFF;
            11'd1:   bar_rgb = 12'hFF0;
            11'd2:   bar_rgb = 12'h0FF;
            11'd3:   bar_rgb = 12'h0F0;
            11'd4:   bar_rgb = 12'hF0F;
            11'd5:   bar_rgb = 12'hF00;
            11'd6:   bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
         endcase
      end
   end

   // Pattern colour registered alongside the counters.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rgb <= 12'h000;
      end else if (clk_en) begin
         rgb <= bar_rgb;
      end
   end
`else
   // Downstream stages paint over a black base.
   assign rgb = 12'h000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Drives two instances: one in the default 1024x768 mode (line-level timing)
// and one in a tiny mode (full frames, mid-frame reset) to keep run time low.
// Expected outputs come from a position model: the raster is simply the count
// of enabled cycles since reset, modulo the frame size, split into (h, v).
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

   logic clk;

   // Default-mode instance signals.
   logic        rst_a, en_a;
   logic [10:0] vcount_a, hcount_a;
   logic        vsync_a, vblnk_a, hsync_a, hblnk_a, frame_tick_a, line_tick_a;
   logic [11:0] rgb_a;

   // Small-mode instance signals.
   logic        rst_b, en_b;
   logic [10:0] vcount_b, hcount_b;
   logic        vsync_b, vblnk_b, hsync_b, hblnk_b, frame_tick_b, line_tick_b;
   logic [11:0] rgb_b;

   int check_count = 0;
   int pass_count  = 0;

   // Per-instance mode description: active, front porch, sync, back porch.
   int ha  [2] = '{1024, 16};
   int hfp [2] = '{24, 2};
   int hsw [2] = '{136, 3};
   int hbp [2] = '{160, 3};
   int va  [2] = '{768, 10};
   int vfp [2] = '{3, 2};
   int vsw [2] = '{6, 2};
   int vbp [2] = '{29, 3};

   // Model state: enabled-cycle position in the frame, whether the last edge
   // advanced, and whether the raster is still sitting in its reset state.
   int p   [2];
   bit adv [2];
   bit rz  [2];

   logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                             12'hF0F, 12'hF00, 12'h00F, 12'h000};

   vga_timing_gen dut_a (
      .clk(clk), .rst(rst_a), .clk_en(en_a),
      .vcount(vcount_a), .vsync(vsync_a), .vblnk(vblnk_a),
      .hcount(hcount_a), .hsync(hsync_a), .hblnk(hblnk_a),
      .rgb(rgb_a), .frame_tick(frame_tick_a), .line_tick(line_tick_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) dut_b (
      .clk(clk), .rst(rst_b), .clk_en(en_b),
      .vcount(vcount_b), .vsync(vsync_b), .vblnk(vblnk_b),
      .hcount(hcount_b), .hsync(hsync_b), .hblnk(hblnk_b),
      .rgb(rgb_b), .frame_tick(frame_tick_b), .line_tick(line_tick_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int total(input int id);
      return (ha[id] + hfp[id] + hsw[id] + hbp[id]) *
             (va[id] + vfp[id] + vsw[id] + vbp[id]);
   endfunction

   // Expected output bundle for the model's current position.
   function automatic logic [39:0] model_vec(input int id);
      int htot, h, v;
      logic hb, vb, hs, vs, ft, lt;
      logic [11:0] col;
      htot = ha[id] + hfp[id] + hsw[id] + hbp[id];
      h  = p[id] % htot;
      v  = p[id] / htot;
      hb = (h >= ha[id]);
      vb = (v >= va[id]);
      hs = !((h >= ha[id] + hfp[id]) && (h < ha[id] + hfp[id] + hsw[id]));
      vs = !((v >= va[id] + vfp[id]) && (v < va[id] + vfp[id] + vsw[id]));
      ft = adv[id] && (h == 0) && (v == va[id]);
      lt = adv[id] && (h == ha[id]);
      col = 12'h000;
`ifdef VGA_TIMING_TEST_PATTERN_EN
      if (!rz[id] && !hb && !vb) col = bars[h / (ha[id] / 8)];
`endif
      return {11'(v), vs, vb, 11'(h), hs, hb, col, ft, lt};
   endfunction

   function automatic logic [39:0] dut_vec(input int id);
      if (id == 0)
         return {vcount_a, vsync_a, vblnk_a, hcount_a, hsync_a, hblnk_a,
                 rgb_a, frame_tick_a, line_tick_a};
      return {vcount_b, vsync_b, vblnk_b, hcount_b, hsync_b, hblnk_b,
              rgb_b, frame_tick_b, line_tick_b};
   endfunction

   task automatic checkOutput(input string tag, input logic [39:0] actual,
                              input logic [39:0] expected);
      check_count++;
      if (actual === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s at %0t: got %h, want %h", tag, $time, actual, expected);
      end
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, then
   // compare the whole output bundle on the falling edge.
   task automatic applyStimulus(input int id, input bit r, input bit en);
      if (id == 0) begin
         rst_a = r; en_a = en;
      end else begin
         rst_b = r; en_b = en;
      end
      @(posedge clk);
      if (!r) begin
         p[id] = 0; adv[id] = 1'b0; rz[id] = 1'b1;
      end else if (en) begin
         p[id] = (p[id] + 1) % total(id); adv[id] = 1'b1; rz[id] = 1'b0;
      end else begin
         adv[id] = 1'b0;
      end
      @(negedge clk);
      checkOutput(id == 0 ? "raster_a" : "raster_b", dut_vec(id), model_vec(id));
   endtask

   initial begin
      int hs_low, lt_cnt, lt_h, ft_cnt;
      rst_a = 1'b0; en_a = 1'b0;
      rst_b = 1'b0; en_b = 1'b0;

      // Reset state of the default-mode instance.
      applyStimulus(0, 1'b0, 1'b1);
      applyStimulus(0, 1'b0, 1'b0);
      checkOutput("reset_a", dut_vec(0), {11'd0, 1'b1, 1'b0, 11'd0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0});

      // One full line with the pixel clock always enabled.
      hs_low = 0; lt_cnt = 0; lt_h = -1;
      for (int i = 0; i < 1344; i++) begin
         applyStimulus(0, 1'b1, 1'b1);
         if (hsync_a == 1'b0) hs_low++;
         if (line_tick_a) begin
            lt_cnt++;
            lt_h = int'(hcount_a);
         end
         if (hcount_a == 11'd128) checkOutput("rgb_h128", 40'(rgb_a),
`ifdef VGA_TIMING_TEST_PATTERN_EN
            40'h0FF0);
`else
            40'h0000);
`endif
         if (hcount_a == 11'd1024) checkOutput("rgb_h1024", 40'(rgb_a), 40'h0000);
      end
      checkOutput("hsync_low_cycles", 40'(hs_low), 40'd136);
      checkOutput("line_tick_count", 40'(lt_cnt), 40'd1);
      checkOutput("line_tick_hcount", 40'(lt_h), 40'd1024);
      checkOutput("line_wrap_hcount", 40'(hcount_a), 40'd0);
      checkOutput("line_wrap_vcount", 40'(vcount_a), 40'd1);

      // Enable pattern 1,0,0,1 and then random enables.
      for (int i = 0; i < 800; i++)
         applyStimulus(0, 1'b1, (i % 4 == 0) || (i % 4 == 3));
      for (int i = 0; i < 1500; i++)
         applyStimulus(0, 1'b1, $urandom_range(0, 3) != 0);

      // Small mode: two full frames from reset, always enabled.
      applyStimulus(1, 1'b0, 1'b1);
      checkOutput("reset_b", dut_vec(1), {11'd0, 1'b1, 1'b0, 11'd0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0});
      ft_cnt = 0;
      for (int i = 0; i < 408; i++) begin
         applyStimulus(1, 1'b1, 1'b1);
         if (frame_tick_b) begin
            ft_cnt++;
            checkOutput("frame_tick_pos", {29'd0, vcount_b}, 40'd10);
         end
      end
      checkOutput("frame1_ticks", 40'(ft_cnt), 40'd1);
      checkOutput("frame1_home", 40'({vcount_b, hcount_b}), 40'd0);
      for (int i = 0; i < 408; i++) begin
         applyStimulus(1, 1'b1, 1'b1);
         if (frame_tick_b) ft_cnt++;
      end
      checkOutput("frame2_ticks", 40'(ft_cnt), 40'd2);

      // Mid-hsync, mid-vsync reset at (19, 13).
      applyStimulus(1, 1'b0, 1'b1);
      for (int i = 0; i < 331; i++) applyStimulus(1, 1'b1, 1'b1);
      checkOutput("mid_pos", 40'({vcount_b, hcount_b}), 40'({11'd13, 11'd19}));
      checkOutput("mid_syncs", 40'({hsync_b, vsync_b}), 40'd0);
      applyStimulus(1, 1'b0, 1'b1);
      checkOutput("mid_reset", dut_vec(1), {11'd0, 1'b1, 1'b0, 11'd0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0});

      // Random enables with occasional resets over several frames.
      for (int i = 0; i < 3000; i++)
         applyStimulus(1, $urandom_range(0, 499) != 0, $urandom_range(0, 9) < 7);

      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
